apb_master_ctrl: RTL and testbench

//  APB initiator (requester side) that turns a simple valid/ready command port into APB

---
 rtl/apb_master_ctrl.sv | 178 +++++++++++++++++
 tb/tb_apb_master_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// APB requester: converts a valid/ready command port into APB SETUP/ACCESS transfers,
// one outstanding transfer, with wait-state timeout and one response strobe per command.
module apb_master_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  localparam int               CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit               TO_EN     = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              psel_q,      psel_d;
  logic              penable_q,   penable_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic              pwrite_q,    pwrite_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;
  logic              timeout_hit;

  // The counter holds completed low-pready ACCESS cycles, so the last allowed one aborts.
  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;

    case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          state_d     = ST_SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          paddr_d     = cmd_addr & ADDR_MASK;
          pwrite_d    = cmd_write;
          pwdata_d    = cmd_wdata;
          cnt_d       = {CNT_W{1'b0}};
        end else begin
          cmd_ready_d = 1'b1;
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end

      ST_ACCESS: begin
        if (pready) begin
          // A ready slave wins even on the cycle the timeout would fire.
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? {DATA_W{1'b0}} : prdata;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
          if (timeout_hit) begin
            state_d     = ST_RESP;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = {DATA_W{1'b0}};
          end else begin
            psel_d    = 1'b1;
            penable_d = 1'b1;
          end
        end
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  // State and registered-output flops; reset clears every output including cmd_ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= {ADDR_W{1'b0}};
      pwrite_q    <= 1'b0;
      pwdata_q    <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Testbench for apb_master_ctrl: behavioural APB slave with configurable wait states,
// response scoreboard, and one task per scenario.
module tb_apb_master_ctrl;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  always #5 clk = ~clk;

  apb_master_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  // Slave model: sram-like memory or fixed data, N wait states, optional error.
  logic [31:0] mem [0:1023];
  int          slv_waits   = 1;
  logic        slv_err     = 1'b0;
  logic        slv_use_mem = 1'b1;
  logic [31:0] slv_data    = 32'h0;
  int          wcnt        = 0;

  assign pready  = psel && penable && (wcnt >= slv_waits);
  assign prdata  = slv_use_mem ? mem[paddr[11:2]] : slv_data;
  assign pslverr = pready && slv_err;

  always @(posedge clk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (psel && penable && pready && pwrite && slv_use_mem) mem[paddr[11:2]] <= pwdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard of expected responses
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   rsp_cnt = 0;

  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=%h err=%0b, required no response",
                 rsp_rdata, rsp_err);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
          errors++;
          $display("FAIL rsp_data: got rdata=%h err=%0b, required rdata=%h err=%0b",
                   rsp_rdata, rsp_err, e.rdata, e.err);
        end
      end
    end
  end

  function automatic logic [31:0] pat(input int i);
    pat = 32'hA5C3_0000 + 32'(i * 32'h0101);
  endfunction

  // Issue one command; returns cycles from accept edge to rsp_valid and ACCESS cycle count.
  task automatic do_cmd(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err,
                        output int lat, output int acc);
    bit   ok;
    bit   unstable;
    rsp_t e;
    ok = 1'b0;
    unstable = 1'b0;
    lat = -1;
    acc = -1;
    for (int k = 0; k < 50; k++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL cmd_ready_wait: got cmd_ready=%0b after 50 cycles, required 1", cmd_ready);
      return;
    end
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    e.rdata = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_addr  = ~addr;
    cmd_wdata = ~wd;
    lat = 1;
    acc = 0;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      if (penable === 1'b1) acc++;
      if (psel === 1'b1 && (paddr !== {addr[11:2], 2'b00} || pwrite !== wr || (wr && pwdata !== wd)))
        unstable = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_wait: got no rsp_valid within 100 cycles, required a response");
    end
    checks++;
    if (unstable) begin
      errors++;
      $display("FAIL apb_stable: got paddr/pwrite/pwdata change during transfer, required addr=%h", addr);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, paddr, pwrite, pwdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%0b rv=%0b psel=%0b pen=%0b, required all 0",
               cmd_ready, rsp_valid, psel, penable);
    end
    #10 rstn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %0b required 0", cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %0b required 1", cmd_ready);
    end
  endtask

  task automatic test_sram();
    int lat, acc;
    slv_use_mem = 1'b1; slv_waits = 1; slv_err = 1'b0;
    do_cmd(1'b1, 12'h004, 32'hDEADBEEF, 32'h0, 1'b0, lat, acc);
    checks++;
    if (lat !== 4 || acc !== 2) begin
      errors++;
      $display("FAIL sram_write_timing: got lat=%0d access=%0d, required lat=4 access=2", lat, acc);
    end
    do_cmd(1'b0, 12'h004, 32'h0, 32'hDEADBEEF, 1'b0, lat, acc);
    checks++;
    if (lat !== 4 || acc !== 2) begin
      errors++;
      $display("FAIL sram_read_timing: got lat=%0d access=%0d, required lat=4 access=2", lat, acc);
    end
  endtask

  task automatic test_zero_wait();
    rsp_t e;
    bit   ok;
    slv_use_mem = 1'b0; slv_waits = 0; slv_data = 32'hCAFEF00D;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL zw_ready_wait: got cmd_ready=0 for 20 cycles, required 1");
    end
    cmd_write = 1'b0; cmd_addr = 12'h023; cmd_valid = 1'b1;
    e.rdata = 32'hCAFEF00D; e.err = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if ({psel, penable, cmd_ready, rsp_valid} !== 4'b1000 || paddr !== 12'h020) begin
      errors++;
      $display("FAIL zw_cycle1: got psel=%0b pen=%0b ready=%0b rv=%0b paddr=%h, required 1 0 0 0 020",
               psel, penable, cmd_ready, rsp_valid, paddr);
    end
    @(posedge clk); #1;
    checks++;
    if ({psel, penable, cmd_ready, rsp_valid} !== 4'b1100) begin
      errors++;
      $display("FAIL zw_cycle2: got psel=%0b pen=%0b ready=%0b rv=%0b, required 1 1 0 0",
               psel, penable, cmd_ready, rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({psel, penable, cmd_ready, rsp_valid} !== 4'b0001) begin
      errors++;
      $display("FAIL zw_cycle3: got psel=%0b pen=%0b ready=%0b rv=%0b, required 0 0 0 1",
               psel, penable, cmd_ready, rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({psel, penable, cmd_ready, rsp_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL zw_cycle4: got psel=%0b pen=%0b ready=%0b rv=%0b, required 0 0 1 0",
               psel, penable, cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_timeout();
    int lat, acc;
    slv_use_mem = 1'b0; slv_waits = 1000; slv_data = 32'hAAAA5555; slv_err = 1'b0;
    do_cmd(1'b0, 12'h010, 32'h0, 32'h0, 1'b1, lat, acc);
    checks++;
    if (lat !== 18 || acc !== TIMEOUT || psel !== 1'b0 || penable !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: got lat=%0d access=%0d psel=%0b pen=%0b, required 18 16 0 0",
               lat, acc, psel, penable);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_idle: got cmd_ready=%0b required 1", cmd_ready);
    end
    // pready on the final allowed cycle completes normally
    slv_waits = TIMEOUT - 1; slv_data = 32'h0BADCAFE;
    do_cmd(1'b0, 12'h014, 32'h0, 32'h0BADCAFE, 1'b0, lat, acc);
    checks++;
    if (lat !== 18 || acc !== TIMEOUT) begin
      errors++;
      $display("FAIL timeout_edge: got lat=%0d access=%0d, required 18 16", lat, acc);
    end
  endtask

  task automatic test_slverr();
    int lat, acc;
    slv_use_mem = 1'b0; slv_waits = 0; slv_err = 1'b1; slv_data = 32'h12345678;
    do_cmd(1'b0, 12'h018, 32'h0, 32'h12345678, 1'b1, lat, acc);
    checks++;
    if (lat !== 3 || acc !== 1) begin
      errors++;
      $display("FAIL slverr_timing: got lat=%0d access=%0d, required 3 1", lat, acc);
    end
    slv_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    int  base;
    bit  ok;
    slv_use_mem = 1'b0; slv_waits = 1000;
    @(posedge clk); #1;
    base = rsp_cnt;
    cmd_write = 1'b0; cmd_addr = 12'h030; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (penable === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rmid_access: got penable=0 for 10 cycles, required 1");
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({psel, penable, cmd_ready} !== 3'b000) begin
      errors++;
      $display("FAIL rmid_async_drop: got psel=%0b pen=%0b ready=%0b, required 0 0 0",
               psel, penable, cmd_ready);
    end
    @(posedge clk); @(posedge clk); #2;
    rstn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_ready_early: got %0b required 0", cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || psel !== 1'b0 || rsp_cnt !== base) begin
      errors++;
      $display("FAIL rmid_restart: got ready=%0b psel=%0b responses=%0d, required 1 0 %0d",
               cmd_ready, psel, rsp_cnt, base);
    end
  endtask

  task automatic test_back_to_back();
    int   acc_cyc[4];
    int   base;
    int   lat, acc;
    bit   ok;
    bit   rdy;
    rsp_t e;
    slv_use_mem = 1'b1; slv_waits = 1; slv_err = 1'b0;
    base = rsp_cnt;
    cmd_write = 1'b1; cmd_addr = 12'h000; cmd_wdata = pat(0); cmd_valid = 1'b1;
    e.rdata = 32'h0; e.err = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        rdy = cmd_ready;
        @(posedge clk); #1;
        if (rdy) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL b2b_accept: got no accept for command %0d, required accept", i);
        break;
      end
      acc_cyc[i] = cyc;
      if (i < 3) begin
        cmd_addr = 12'((i + 1) * 4); cmd_wdata = pat(i + 1);
        exp_q.push_back(e);
      end else begin
        cmd_valid = 1'b0;
      end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (psel !== 1'b1 || pwrite !== 1'b1 || paddr !== 12'(i * 4) || pwdata !== pat(i)) begin
          errors++;
          $display("FAIL b2b_stable: cmd %0d cycle %0d got psel=%0b paddr=%h pwdata=%h, required 1 %h %h",
                   i, c, psel, paddr, pwdata, 12'(i * 4), pat(i));
        end
        if (c < 2) begin
          @(posedge clk); #1;
        end
      end
    end
    cmd_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] !== 5) begin
        errors++;
        $display("FAIL b2b_spacing: accept %0d got gap %0d, required 5", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (rsp_cnt - base !== 4) begin
      errors++;
      $display("FAIL b2b_responses: got %0d required 4", rsp_cnt - base);
    end
    do_cmd(1'b0, 12'h008, 32'h0, pat(2), 1'b0, lat, acc);
  endtask

  initial begin
    test_reset();
    test_sram();
    test_zero_wait();
    test_timeout();
    test_slverr();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending responses, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
